// File: rtl/mccu_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// function fields, ALU ops, next-PC selects and the decoded-instruction record.
package mccu_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  typedef struct packed {
    logic       legal;
    logic       is_jr;
    logic       is_j;
    logic       is_jal;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_bne;
    logic       aluimm;
    logic       shift;
    logic       sext;
    logic       regrt;
    logic [3:0] aluc;
  } dec_t;

  localparam dec_t DEC_NONE = '{default: 1'b0};

endpackage

// File: rtl/mccu_decode.sv
// Combinational instruction decoder: op/func to instruction-class flags and
// the ALU/datapath selects shared by the EXE and WB states.
module mccu_decode
  import mccu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output dec_t       dec
);

  // Classify the instruction; anything not listed stays at DEC_NONE (illegal).
  always_comb begin
    dec = DEC_NONE;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD: begin dec.legal = 1'b1; dec.aluc = ALUC_ADD; end
          FN_SUB: begin dec.legal = 1'b1; dec.aluc = ALUC_SUB; end
          FN_AND: begin dec.legal = 1'b1; dec.aluc = ALUC_AND; end
          FN_OR:  begin dec.legal = 1'b1; dec.aluc = ALUC_OR;  end
          FN_XOR: begin dec.legal = 1'b1; dec.aluc = ALUC_XOR; end
          FN_SLL: begin dec.legal = 1'b1; dec.shift = 1'b1; dec.aluc = ALUC_SLL; end
          FN_SRL: begin dec.legal = 1'b1; dec.shift = 1'b1; dec.aluc = ALUC_SRL; end
          FN_SRA: begin dec.legal = 1'b1; dec.shift = 1'b1; dec.aluc = ALUC_SRA; end
          FN_JR:  begin dec.legal = 1'b1; dec.is_jr = 1'b1; end
          default: dec = DEC_NONE;
        endcase
      end
      OP_ADDI: begin
        dec.legal = 1'b1; dec.aluimm = 1'b1; dec.sext = 1'b1; dec.regrt = 1'b1;
        dec.aluc = ALUC_ADD;
      end
      OP_ANDI: begin dec.legal = 1'b1; dec.aluimm = 1'b1; dec.regrt = 1'b1; dec.aluc = ALUC_AND; end
      OP_ORI:  begin dec.legal = 1'b1; dec.aluimm = 1'b1; dec.regrt = 1'b1; dec.aluc = ALUC_OR;  end
      OP_XORI: begin dec.legal = 1'b1; dec.aluimm = 1'b1; dec.regrt = 1'b1; dec.aluc = ALUC_XOR; end
      OP_LUI:  begin dec.legal = 1'b1; dec.aluimm = 1'b1; dec.regrt = 1'b1; dec.aluc = ALUC_LUI; end
      OP_LW: begin
        dec.legal = 1'b1; dec.is_lw = 1'b1; dec.aluimm = 1'b1; dec.sext = 1'b1;
        dec.regrt = 1'b1; dec.aluc = ALUC_ADD;
      end
      OP_SW: begin
        dec.legal = 1'b1; dec.is_sw = 1'b1; dec.aluimm = 1'b1; dec.sext = 1'b1;
        dec.aluc = ALUC_ADD;
      end
      OP_BEQ: begin dec.legal = 1'b1; dec.is_beq = 1'b1; dec.sext = 1'b1; dec.aluc = ALUC_SUB; end
      OP_BNE: begin dec.legal = 1'b1; dec.is_bne = 1'b1; dec.sext = 1'b1; dec.aluc = ALUC_SUB; end
      OP_J:    begin dec.legal = 1'b1; dec.is_j = 1'b1; end
      OP_JAL:  begin dec.legal = 1'b1; dec.is_jal = 1'b1; end
      default: dec = DEC_NONE;
    endcase
  end

endmodule

// File: rtl/mccu_fsm.sv
// Multi-cycle MIPS control unit: IF/ID/EXE/MEM/WB sequencer with a bounded
// memory-wait watchdog. Outputs decode combinationally from state and inputs.
module mccu_fsm
  import mccu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_rdy,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       shift,
  output logic       aluimm,
  output logic       jal,
  output logic       sext,
  output logic [3:0] aluc,
  output logic [1:0] pcsource,
  output logic       illegal,
  output logic       timeout,
  output logic [2:0] state
);

  localparam int CW = (WAIT_MAX < 32'd1) ? 1 : $clog2(WAIT_MAX + 32'd1);
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  state_t          state_r;
  state_t          next_s;
  logic [CW-1:0]   cnt_r;
  dec_t            dec_s;
  logic            wait_s;
  logic            wpc_s, wir_s, wmem_s, wreg_s, illegal_s, timeout_s;

  mccu_decode u_decode (
    .op   (op),
    .func (func),
    .dec  (dec_s)
  );

  assign wait_s = ((state_r == S_IF) || (state_r == S_MEM)) && !mem_rdy;

  // Next-state and control-output decode for the current state.
  always_comb begin
    next_s    = S_IF;
    wpc_s     = 1'b0;
    wir_s     = 1'b0;
    wmem_s    = 1'b0;
    wreg_s    = 1'b0;
    illegal_s = 1'b0;
    timeout_s = 1'b0;
    iord      = 1'b0;
    regrt     = 1'b0;
    m2reg     = 1'b0;
    shift     = 1'b0;
    aluimm    = 1'b0;
    jal       = 1'b0;
    sext      = 1'b0;
    aluc      = ALUC_ADD;
    pcsource  = PC_SEQ;
    case (state_r)
      S_IF: begin
        if (mem_rdy) begin
          wir_s  = 1'b1;
          wpc_s  = 1'b1;
          next_s = S_ID;
        end else if (cnt_r == WAIT_LIM) begin
          timeout_s = 1'b1;
          next_s    = S_IF;
        end else begin
          next_s = S_IF;
        end
      end
      S_ID: begin
        if (dec_s.is_j) begin
          wpc_s    = 1'b1;
          pcsource = PC_JMP;
        end else if (dec_s.is_jal) begin
          wpc_s    = 1'b1;
          pcsource = PC_JMP;
          jal      = 1'b1;
          wreg_s   = 1'b1;
        end else if (dec_s.is_jr) begin
          wpc_s    = 1'b1;
          pcsource = PC_JR;
        end else if (!dec_s.legal) begin
          illegal_s = 1'b1;
        end else begin
          next_s = S_EXE;
        end
      end
      S_EXE: begin
        aluc   = dec_s.aluc;
        aluimm = dec_s.aluimm;
        shift  = dec_s.shift;
        sext   = dec_s.sext;
        if (dec_s.is_beq || dec_s.is_bne) begin
          if ((dec_s.is_beq && z) || (dec_s.is_bne && !z)) begin
            wpc_s    = 1'b1;
            pcsource = PC_BR;
          end else begin
            wpc_s = 1'b0;
          end
        end else if (dec_s.is_lw || dec_s.is_sw) begin
          next_s = S_MEM;
        end else begin
          next_s = S_WB;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        if (mem_rdy) begin
          wmem_s = dec_s.is_sw;
          next_s = dec_s.is_lw ? S_WB : S_IF;
        end else if (cnt_r == WAIT_LIM) begin
          // Watchdog abort: suppress the store so memory is left untouched.
          timeout_s = 1'b1;
        end else begin
          wmem_s = dec_s.is_sw;
          next_s = S_MEM;
        end
      end
      S_WB: begin
        wreg_s = 1'b1;
        m2reg  = dec_s.is_lw;
        regrt  = dec_s.regrt;
        aluc   = dec_s.aluc;
        aluimm = dec_s.aluimm;
        shift  = dec_s.shift;
        sext   = dec_s.sext;
      end
      default: next_s = S_IF;
    endcase
  end

  // State register and wait counter; counter restarts on every state entry or timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IF;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= next_s;
      if (timeout_s || (next_s != state_r)) begin
        cnt_r <= {CW{1'b0}};
      end else if (wait_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign wpc     = wpc_s     & ~rst;
  assign wir     = wir_s     & ~rst;
  assign wmem    = wmem_s    & ~rst;
  assign wreg    = wreg_s    & ~rst;
  assign illegal = illegal_s & ~rst;
  assign timeout = timeout_s & ~rst;
  assign state   = state_r;

endmodule

// File: tb/tb_mccu_fsm.sv
// Directed plus randomized bench for mccu_fsm; expected per-cycle control
// traces are built from instruction classes and memory-wait counts.
module tb_mccu_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0, func = 6'd0;
  logic       z = 1'b0, mem_rdy = 1'b0;
  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, aluimm, jal, sext;
  logic [3:0] aluc;
  logic [1:0] pcsource;
  logic       illegal, timeout;
  logic [2:0] state;

  always #5 clk = ~clk;

  mccu_fsm #(.WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
    .wpc(wpc), .wir(wir), .wmem(wmem), .wreg(wreg), .iord(iord), .regrt(regrt),
    .m2reg(m2reg), .shift(shift), .aluimm(aluimm), .jal(jal), .sext(sext),
    .aluc(aluc), .pcsource(pcsource), .illegal(illegal), .timeout(timeout),
    .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, aluimm, jal, sext;
    logic [3:0] aluc;
    logic [1:0] pcs;
    logic illegal, timeout;
  } obs_t;

  obs_t obs;
  assign obs = {state, wpc, wir, wmem, wreg, iord, regrt, m2reg, shift, aluimm,
                jal, sext, aluc, pcsource, illegal, timeout};

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_BNE = 5;
  localparam int C_J = 6, C_JAL = 7, C_JR = 8, C_BAD = 9;
  localparam int LIMIT = 15;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         cls;
    logic [3:0] aluc;
    logic       aluimm, shift, sext, regrt;
  } ins_t;

  ins_t tbl[22];
  int   n_vec = 0;
  int   n_err = 0;
  bit   hold_rdy = 1'b0;

  function automatic ins_t mk(input logic [5:0] o, input logic [5:0] f, input int c,
                              input logic [3:0] a, input logic ai, input logic sh,
                              input logic se, input logic rt);
    ins_t t;
    t.op = o; t.fn = f; t.cls = c; t.aluc = a;
    t.aluimm = ai; t.shift = sh; t.sext = se; t.regrt = rt;
    return t;
  endfunction

  function automatic obs_t blank(input logic [2:0] st);
    obs_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic obs_t alu_sel(input logic [2:0] st, input ins_t t);
    obs_t e;
    e = blank(st);
    e.aluc = t.aluc; e.aluimm = t.aluimm; e.shift = t.shift; e.sext = t.sext;
    return e;
  endfunction

  function automatic logic idle_rdy();
    return hold_rdy ? 1'b1 : 1'($urandom);
  endfunction

  task automatic step(input obs_t e, input logic r, input logic zz, input string tag,
                      input logic rs = 1'b0);
    mem_rdy = r; z = zz; rst = rs;
    @(negedge clk);
    n_vec++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
    @(posedge clk); #1;
  endtask

  // Instruction fetch: w low mem_rdy cycles, every 16th consecutive one times out.
  task automatic fetch(input int w, input string tag);
    obs_t e;
    int k;
    k = 0;
    for (int i = 0; i < w; i++) begin
      e = blank(3'd0);
      if (k == LIMIT) begin e.timeout = 1'b1; k = 0; end
      else k++;
      step(e, 1'b0, 1'($urandom), tag);
    end
    e = blank(3'd0); e.wir = 1'b1; e.wpc = 1'b1;
    step(e, 1'b1, 1'($urandom), tag);
  endtask

  task automatic run_instr(input int idx, input int fw, input int mw, input logic zz,
                           input string tag);
    ins_t t;
    obs_t e;
    t = tbl[idx];
    op = t.op;
    func = (t.op == 6'b000000) ? t.fn : 6'($urandom);
    fetch(fw, tag);
    e = blank(3'd1);
    case (t.cls)
      C_J:   begin e.wpc = 1'b1; e.pcs = 2'b11; end
      C_JAL: begin e.wpc = 1'b1; e.pcs = 2'b11; e.jal = 1'b1; e.wreg = 1'b1; end
      C_JR:  begin e.wpc = 1'b1; e.pcs = 2'b10; end
      C_BAD: e.illegal = 1'b1;
      default: ;
    endcase
    step(e, idle_rdy(), 1'($urandom), tag);
    if (t.cls == C_J || t.cls == C_JAL || t.cls == C_JR || t.cls == C_BAD) return;
    e = alu_sel(3'd2, t);
    if (t.cls == C_BEQ || t.cls == C_BNE) begin
      if ((t.cls == C_BEQ && zz) || (t.cls == C_BNE && !zz)) begin
        e.wpc = 1'b1; e.pcs = 2'b01;
      end
      step(e, idle_rdy(), zz, tag);
      return;
    end
    step(e, idle_rdy(), 1'($urandom), tag);
    if (t.cls == C_LW || t.cls == C_SW) begin
      for (int i = 0; i < mw; i++) begin
        e = blank(3'd3); e.iord = 1'b1;
        if (i == LIMIT) begin
          e.timeout = 1'b1;
          step(e, 1'b0, 1'($urandom), tag);
          return;
        end
        e.wmem = (t.cls == C_SW);
        step(e, 1'b0, 1'($urandom), tag);
      end
      e = blank(3'd3); e.iord = 1'b1; e.wmem = (t.cls == C_SW);
      step(e, 1'b1, 1'($urandom), tag);
      if (t.cls == C_SW) return;
    end
    e = alu_sel(3'd4, t);
    e.wreg = 1'b1; e.m2reg = (t.cls == C_LW); e.regrt = t.regrt;
    step(e, idle_rdy(), 1'($urandom), tag);
  endtask

  initial begin
    obs_t e;
    tbl[0]  = mk(6'b000000, 6'b100000, C_R,   4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); // add
    tbl[1]  = mk(6'b000000, 6'b100010, C_R,   4'b0100, 1'b0, 1'b0, 1'b0, 1'b0); // sub
    tbl[2]  = mk(6'b000000, 6'b100100, C_R,   4'b0001, 1'b0, 1'b0, 1'b0, 1'b0); // and
    tbl[3]  = mk(6'b000000, 6'b100101, C_R,   4'b0101, 1'b0, 1'b0, 1'b0, 1'b0); // or
    tbl[4]  = mk(6'b000000, 6'b100110, C_R,   4'b0010, 1'b0, 1'b0, 1'b0, 1'b0); // xor
    tbl[5]  = mk(6'b000000, 6'b000000, C_R,   4'b0011, 1'b0, 1'b1, 1'b0, 1'b0); // sll
    tbl[6]  = mk(6'b000000, 6'b000010, C_R,   4'b0111, 1'b0, 1'b1, 1'b0, 1'b0); // srl
    tbl[7]  = mk(6'b000000, 6'b000011, C_R,   4'b1111, 1'b0, 1'b1, 1'b0, 1'b0); // sra
    tbl[8]  = mk(6'b000000, 6'b001000, C_JR,  4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); // jr
    tbl[9]  = mk(6'b001000, 6'b000000, C_I,   4'b0000, 1'b1, 1'b0, 1'b1, 1'b1); // addi
    tbl[10] = mk(6'b001100, 6'b000000, C_I,   4'b0001, 1'b1, 1'b0, 1'b0, 1'b1); // andi
    tbl[11] = mk(6'b001101, 6'b000000, C_I,   4'b0101, 1'b1, 1'b0, 1'b0, 1'b1); // ori
    tbl[12] = mk(6'b001110, 6'b000000, C_I,   4'b0010, 1'b1, 1'b0, 1'b0, 1'b1); // xori
    tbl[13] = mk(6'b001111, 6'b000000, C_I,   4'b0110, 1'b1, 1'b0, 1'b0, 1'b1); // lui
    tbl[14] = mk(6'b100011, 6'b000000, C_LW,  4'b0000, 1'b1, 1'b0, 1'b1, 1'b1); // lw
    tbl[15] = mk(6'b101011, 6'b000000, C_SW,  4'b0000, 1'b1, 1'b0, 1'b1, 1'b0); // sw
    tbl[16] = mk(6'b000100, 6'b000000, C_BEQ, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0); // beq
    tbl[17] = mk(6'b000101, 6'b000000, C_BNE, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0); // bne
    tbl[18] = mk(6'b000010, 6'b000000, C_J,   4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); // j
    tbl[19] = mk(6'b000011, 6'b000000, C_JAL, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); // jal
    tbl[20] = mk(6'b111111, 6'b000000, C_BAD, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); // bad op
    tbl[21] = mk(6'b000000, 6'b111111, C_BAD, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0); // bad func

    rst = 1'b1; mem_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset held with mem_rdy high: IF, but no write enables.
    step(blank(3'd0), 1'b1, 1'b0, "reset", 1'b1);

    hold_rdy = 1'b1;
    run_instr(0, 0, 0, 1'b0, "add");
    hold_rdy = 1'b0;
    run_instr(14, 1, 3, 1'b0, "lw_wait3");
    run_instr(15, 0, 2, 1'b0, "sw_wait2");
    run_instr(16, 0, 0, 1'b1, "beq_z1");
    run_instr(16, 0, 0, 1'b0, "beq_z0");
    run_instr(17, 0, 0, 1'b0, "bne_z0");
    run_instr(17, 0, 0, 1'b1, "bne_z1");
    run_instr(19, 0, 0, 1'b0, "jal");
    run_instr(20, 0, 0, 1'b0, "illegal_op");
    run_instr(21, 0, 0, 1'b0, "illegal_fn");
    run_instr(18, 0, 0, 1'b0, "j");
    run_instr(8, 0, 0, 1'b0, "jr");
    run_instr(7, 16, 0, 1'b0, "if_timeout");
    run_instr(5, 15, 0, 1'b0, "if_rdy_at_limit");
    run_instr(15, 0, 16, 1'b0, "sw_mem_timeout");
    run_instr(14, 0, 15, 1'b0, "lw_rdy_at_limit");

    // Reset in the middle of a store's memory phase.
    op = 6'b101011; func = 6'd0;
    fetch(0, "rst_mid_mem");
    step(blank(3'd1), 1'b0, 1'b0, "rst_mid_mem");
    step(alu_sel(3'd2, tbl[15]), 1'b0, 1'b0, "rst_mid_mem");
    e = blank(3'd3); e.iord = 1'b1; e.wmem = 1'b1;
    step(e, 1'b0, 1'b0, "rst_mid_mem");
    e.wmem = 1'b0;
    step(e, 1'b0, 1'b0, "rst_mid_mem_asserted", 1'b1);
    run_instr(10, 15, 0, 1'b0, "after_rst");

    for (int n = 0; n < 60; n++) begin
      int idx, fw, mw;
      idx = $urandom_range(0, 21);
      fw = ($urandom_range(0, 7) == 0) ? 17 : $urandom_range(0, 3);
      mw = ($urandom_range(0, 7) == 0) ? 16 : $urandom_range(0, 4);
      run_instr(idx, fw, mw, 1'($urandom), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
